markov_table_merge: RTL and testbench

- Merges two packed Markov chain tables (A and B) into one compacted output table.
- Each table entry is a sequence key plus an occurrence count.
- Identical keys are combined by saturating count addition. New keys are appended. Empty entries (count 0) are dropped.
- Sits after the MachineLearningMarkov learners and forms the first/second merge tree levels. Its start is driven by the AND of upstream done flags, and its done feeds the next merge level.

---
 rtl/markov_table_merge.sv | 133 +++++++++++++
 tb/tb_markov_table_merge.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/markov_table_merge.sv
// Merges two packed Markov tables (key + count entries) into one compacted output table.
// One source entry is scanned per clock: all of A first, then all of B.
module markov_table_merge #(
  parameter  int KEY_W   = 24,
  parameter  int CNT_W   = 8,
  parameter  int DEPTH   = 16,
  localparam int ENTRY_W = KEY_W + CNT_W,
  localparam int IDX_W   = $clog2(2 * DEPTH),
  localparam int USED_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DEPTH*ENTRY_W-1:0] tableA,
  input  logic [DEPTH*ENTRY_W-1:0] tableB,
  output logic [DEPTH*ENTRY_W-1:0] tableOut,
  output logic [USED_W-1:0]        used,
  output logic                     overflow,
  output logic                     busy,
  output logic                     done
);

  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  DEPTH_I  = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(2 * DEPTH - 1);
  localparam logic [USED_W-1:0] FULL     = USED_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ENTRY_W-1:0]  tbl_q [DEPTH];
  logic [USED_W-1:0]   used_q;
  logic                overflow_q;
  logic                busy_q;
  logic                done_q;

  logic [ENTRY_W-1:0]  a_ent [DEPTH];
  logic [ENTRY_W-1:0]  b_ent [DEPTH];
  logic [CNT_W-1:0]    sat_cnt [DEPTH];
  logic [DEPTH-1:0]    hit_vec;
  logic [SEL_W-1:0]    sel_d;
  logic [ENTRY_W-1:0]  src_d;
  logic [KEY_W-1:0]    src_key;
  logic [CNT_W-1:0]    src_cnt;

  always_comb begin
    if (idx_q < DEPTH_I) begin
      sel_d = SEL_W'(idx_q);
      src_d = a_ent[sel_d];
    end else begin
      sel_d = SEL_W'(idx_q - DEPTH_I);
      src_d = b_ent[sel_d];
    end
  end

  assign src_key = src_d[ENTRY_W-1:CNT_W];
  assign src_cnt = src_d[CNT_W-1:0];

  // Only valid slots can hit; output keys stay unique so hit_vec is at most one-hot.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [CNT_W:0] sum;
    assign a_ent[g] = tableA[g*ENTRY_W +: ENTRY_W];
    assign b_ent[g] = tableB[g*ENTRY_W +: ENTRY_W];
    assign tableOut[g*ENTRY_W +: ENTRY_W] = tbl_q[g];
    assign hit_vec[g] = (tbl_q[g][CNT_W-1:0] != '0) &&
                        (tbl_q[g][ENTRY_W-1:CNT_W] == src_key);
    assign sum = {1'b0, tbl_q[g][CNT_W-1:0]} + {1'b0, src_cnt};
    assign sat_cnt[g] = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      used_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int j = 0; j < DEPTH; j++) tbl_q[j] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < DEPTH; j++) tbl_q[j] <= '0;
            used_q     <= '0;
            overflow_q <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (src_cnt != '0) begin
            if (|hit_vec) begin
              for (int j = 0; j < DEPTH; j++)
                if (hit_vec[j]) tbl_q[j][CNT_W-1:0] <= sat_cnt[j];
            end else if (used_q < FULL) begin
              for (int j = 0; j < DEPTH; j++)
                if (used_q == USED_W'(j)) tbl_q[j] <= src_d;
              used_q <= used_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign used     = used_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_markov_table_merge.sv
// Scoreboard bench for markov_table_merge: stimulus pushes expected tables, a monitor
// compares them when done rises.
module tb_markov_table_merge;

  localparam int KEY_W   = 8;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 4;
  localparam int ENTRY_W = KEY_W + CNT_W;
  localparam int TW      = DEPTH * ENTRY_W;
  localparam int USED_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [TW-1:0]     tA, tB, tOut;
  logic [USED_W-1:0] used;
  logic              overflow, busy, done;

  markov_table_merge #(.KEY_W(KEY_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .tableA(tA), .tableB(tB),
    .tableOut(tOut), .used(used), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0]     tbl;
    logic [USED_W-1:0] u;
    logic              o;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic done_prev = 1'b0;
  int   done_rises = 0;

  function automatic logic [ENTRY_W-1:0] ent(input logic [KEY_W-1:0] k, input logic [CNT_W-1:0] c);
    return {k, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_prev) begin
      exp_t e;
      done_rises++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("tableOut", 64'(tOut), 64'(e.tbl));
        chk("used", 64'(used), 64'(e.u));
        chk("overflow", 64'(overflow), 64'(e.o));
      end
    end
    done_prev = done;
  end

  task automatic run(input logic [TW-1:0] a, input logic [TW-1:0] b,
                     input logic [TW-1:0] et, input logic [USED_W-1:0] eu,
                     input logic eo, input bit hold_after);
    int edges;
    exp_t e;
    @(negedge clk);
    tA = a; tB = b;
    e.tbl = et; e.u = eu; e.o = eo;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (!done) chk("busy_scan", 64'(busy), 64'(1));
    end
    chk("latency", 64'(edges), 64'(2 * DEPTH));
    chk("busy_end", 64'(busy), 64'(0));
    if (hold_after) begin
      repeat (3) @(negedge clk);
      chk("done_hold", 64'(done), 64'(1));
      chk("no_rerun_busy", 64'(busy), 64'(0));
      chk("no_rerun_table", 64'(tOut), 64'(et));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", 64'(done), 64'(0));
    chk("used_retained", 64'(used), 64'(eu));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tableOut"}, 64'(tOut), 64'(0));
    chk({tag, "_used"}, 64'(used), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    int rises_before;
    reset = 1'b1;
    start = 1'b1;
    tA = TW'({$urandom, $urandom});
    tB = TW'({$urandom, $urandom});
    repeat (3) @(negedge clk);
    chk_zero("reset");
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    // disjoint merge, then hold start to confirm no retrigger
    run({12'h0, 12'h0, ent(8'h22, 4'd1), ent(8'h11, 4'd3)},
        {12'h0, 12'h0, 12'h0, ent(8'h33, 4'd2)},
        {12'h0, ent(8'h33, 4'd2), ent(8'h22, 4'd1), ent(8'h11, 4'd3)}, 3'd3, 1'b0, 1'b1);

    // hit with saturation: 12+5 clamps to 15
    run({36'h0, ent(8'h11, 4'd12)}, {36'h0, ent(8'h11, 4'd5)},
        {36'h0, ent(8'h11, 4'd15)}, 3'd1, 1'b0, 1'b0);

    // empty skip and intra-table duplicate
    run({ent(8'h44, 4'd1), ent(8'h11, 4'd3), 12'h0, ent(8'h11, 4'd2)}, {TW{1'b0}},
        {24'h0, ent(8'h44, 4'd1), ent(8'h11, 4'd5)}, 3'd2, 1'b0, 1'b0);

    // overflow: 0x99 dropped, 0x11 still hits after the table is full
    run({ent(8'h44, 4'd1), ent(8'h33, 4'd1), ent(8'h22, 4'd1), ent(8'h11, 4'd1)},
        {24'h0, ent(8'h11, 4'd2), ent(8'h99, 4'd1)},
        {ent(8'h44, 4'd1), ent(8'h33, 4'd1), ent(8'h22, 4'd1), ent(8'h11, 4'd3)},
        3'd4, 1'b1, 1'b0);

    // new run clears the sticky overflow
    run({36'h0, ent(8'h55, 4'd7)}, {36'h0, ent(8'h66, 4'd0)},
        {36'h0, ent(8'h55, 4'd7)}, 3'd1, 1'b0, 1'b0);

    // abort mid-scan
    rises_before = done_rises;
    @(negedge clk);
    tA = {ent(8'h44, 4'd1), ent(8'h33, 4'd1), ent(8'h22, 4'd1), ent(8'h11, 4'd1)};
    tB = {TW{1'b0}};
    start = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_zero("abort");
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(done_rises - rises_before), 64'(0));
    chk("abort_idle_used", 64'(used), 64'(0));
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
